mem_access_unit: RTL

Load/store/atomic initiator that sits between the core's execute stage and the word-addressed `memory` block. It accepts one request at a time over a valid/ready handshake and converts byte addresses to word indices. It sequences the memory's `mem_read`/`mem_write` strobes, including a read-modify-write sequence for RV32A AMOs (e.g. `amoadd.w`). It returns the loaded or old value over a valid/ready response.

---
 rtl/mem_access_unit_pkg.sv | 35 +++
 rtl/mem_access_unit_amo.sv | 34 +++
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: array selects, op codes,
// controller states and small decode helpers.
package mem_access_unit_pkg;

  // Memory array select
  localparam logic MEM_ROM = 1'b0;
  localparam logic MEM_RAM = 1'b1;

  // Operation codes
  localparam logic [3:0] OP_LOAD    = 4'd0;
  localparam logic [3:0] OP_STORE   = 4'd1;
  localparam logic [3:0] OP_AMOSWAP = 4'd2;
  localparam logic [3:0] OP_AMOADD  = 4'd3;
  localparam logic [3:0] OP_AMOXOR  = 4'd4;
  localparam logic [3:0] OP_AMOAND  = 4'd5;
  localparam logic [3:0] OP_AMOOR   = 4'd6;
  localparam logic [3:0] OP_AMOMIN  = 4'd7;
  localparam logic [3:0] OP_AMOMAX  = 4'd8;
  localparam logic [3:0] OP_AMOMINU = 4'd9;
  localparam logic [3:0] OP_AMOMAXU = 4'd10;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // True for any read-modify-write op code
  function automatic logic is_amo(input logic [3:0] op);
    return (op >= OP_AMOSWAP) && (op <= OP_AMOMAXU);
  endfunction

endpackage

// File: rtl/mem_access_unit_amo.sv
// Combinational RV32A AMO arithmetic: new memory value from the old value
// and the rs2 operand. Comparisons keep the old value on ties.
module amo_alu
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] old,
  input  logic [31:0] operand,
  output logic [31:0] result
);

  logic signed [31:0] old_s;
  logic signed [31:0] opnd_s;

  // Select the AMO result for the requested operation
  always_comb begin
    old_s  = old;
    opnd_s = operand;
    result = old;
    case (op)
      OP_AMOSWAP: result = operand;
      OP_AMOADD:  result = old + operand;
      OP_AMOXOR:  result = old ^ operand;
      OP_AMOAND:  result = old & operand;
      OP_AMOOR:   result = old | operand;
      OP_AMOMIN:  result = (opnd_s < old_s) ? operand : old;
      OP_AMOMAX:  result = (opnd_s > old_s) ? operand : old;
      OP_AMOMINU: result = (operand < old) ? operand : old;
      OP_AMOMAXU: result = (operand > old) ? operand : old;
      default:    result = old;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store/AMO initiator in front of the word-addressed
// memory. Requests are latched in IDLE, memory is driven from registered
// state only, and the result is held in RESP until the consumer takes it.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic        req_mem_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic [31:0] address,
  output logic [31:0] input_data,
  output logic        mem_write,
  output logic        mem_read,
  output logic        mem_type,
  input  logic [31:0] output_data
);

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic        type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] word_idx;
  logic        req_err;
  logic [31:0] amo_result;

  assign word_idx = {2'b00, req_addr[31:2]};
  assign req_err  = (req_addr[1:0] != 2'b00)
                 || (word_idx >= 32'(DEPTH))
                 || (req_op > OP_AMOMAXU)
                 || (is_amo(req_op) && (req_mem_type == MEM_ROM));

  // Old value comes straight from memory during READ; operand is the latched rs2
  amo_alu u_amo_alu (
    .op      (op_q),
    .old     (output_data),
    .operand (opnd_q),
    .result  (amo_result)
  );

  // State and datapath registers; everything clears so strobes drop at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      type_q  <= 1'b0;
      addr_q  <= '0;
      opnd_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      opnd_q  <= opnd_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err)                 state_d = ST_RESP;
          else if (req_op == OP_STORE) state_d = ST_WRITE;
          else                         state_d = ST_READ;
        end
      end
      ST_READ:  state_d = (op_q == OP_LOAD) ? ST_RESP : ST_WRITE;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request latch, read capture and AMO write-data update
  always_comb begin
    op_d    = op_q;
    type_d  = type_q;
    addr_d  = addr_q;
    opnd_d  = opnd_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          type_d  = req_mem_type;
          addr_d  = word_idx;
          opnd_d  = req_data;
          rdata_d = '0;
          err_d   = req_err;
          if (!req_err && (req_op == OP_STORE)) wdata_d = req_data;
        end
      end
      ST_READ: begin
        // Loads return this value; AMOs return it as the old value
        rdata_d = output_data;
        if (op_q != OP_LOAD) wdata_d = amo_result;
      end
      default: ;
    endcase
  end

  // Handshake and strobe outputs from registered state only
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state_q)
      ST_IDLE:  req_ready  = 1'b1;
      ST_READ:  mem_read   = 1'b1;
      ST_WRITE: mem_write  = 1'b1;
      ST_RESP:  resp_valid = 1'b1;
      default:  ;
    endcase
  end

  assign address    = addr_q;
  assign mem_type   = type_q;
  assign input_data = wdata_q;
  assign resp_data  = rdata_q;
  assign resp_error = err_q;

endmodule
